mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 124 ++++++++++++
 tb/tb_mem_responder.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the processor memory path: responder state
// encoding, the value returned by a faulting read, and the address check.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mr_state_e;

  localparam logic [31:0] READ_ZERO = 32'h0000_0000;
  localparam int unsigned CNT_W     = 4;

  // Misaligned, or any bit above the word-index field is set.
  function automatic logic adr_err(input logic [31:0] adr, input int unsigned aw);
    return (adr[1:0] != 2'b00) || ((adr >> (aw + 2)) != 32'h0);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor <-> memory responder handshake bundle.
interface mem_responder_if;
  logic        Req;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Busy;
  logic        Err;

  modport master (
    output Req, MemWrite, Adr, WriteData,
    input  ReadData, Ready, Busy, Err
  );

  modport slave (
    input  Req, MemWrite, Adr, WriteData,
    output ReadData, Ready, Busy, Err
  );
endinterface

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module mem_array #(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one access in IDLE, counts out the
// wait states, then completes with a single-cycle Ready pulse.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  mr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             acc_wr;
  logic [31:0]      acc_adr;
  logic [31:0]      acc_wdata;
  logic             acc_err;
  logic             enter_done;
  logic             mem_we;
  logic [31:0]      mem_rdata;

  // With zero wait states DONE is entered on the accepting edge, so the
  // access must be served straight from the bus rather than the latches.
  always_comb begin
    acc_wr    = wr_q;
    acc_adr   = adr_q;
    acc_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      acc_wr    = bus.MemWrite;
      acc_adr   = bus.Adr;
      acc_wdata = bus.WriteData;
    end
    acc_err = adr_err(acc_adr, AW);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Req) begin
          wr_d    = bus.MemWrite;
          adr_d   = bus.Adr;
          wdata_d = bus.WriteData;
          err_d   = acc_err;
          cnt_d   = WAIT_LD;
          if (WAIT_LD == '0) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_done && !acc_wr) rdata_d = acc_err ? READ_ZERO : mem_rdata;
  end

  // Reset on the completing edge aborts the access, so block the write too.
  assign mem_we = enter_done && acc_wr && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= READ_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (acc_adr[AW+1:2]),
    .wdata_i (acc_wdata),
    .raddr_i (acc_adr[AW+1:2]),
    .rdata_o (mem_rdata)
  );

  assign bus.Ready    = (state_q == ST_DONE);
  assign bus.Busy     = (state_q != ST_IDLE);
  assign bus.Err      = (state_q == ST_DONE) && err_q;
  assign bus.ReadData = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  mem_responder_if if2();
  mem_responder_if if0();

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u2 (.clk(clk), .reset(reset), .bus(if2));
  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset(reset), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Two-wait-state access: Ready must appear on the third cycle after the
  // accepting edge, Busy through all three.
  task automatic acc2(input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    if2.Req = 1'b1; if2.MemWrite = wr; if2.Adr = adr; if2.WriteData = wd;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("w2_ready", {31'b0, if2.Ready}, {31'b0, (i == 3)});
      chk("w2_busy",  {31'b0, if2.Busy},  32'd1);
    end
    chk("w2_err", {31'b0, if2.Err}, {31'b0, exp_err});
    chk("w2_rdata", if2.ReadData, exp_rd);
    if2.Req = 1'b0;
    @(negedge clk);
    chk("w2_ready_clr", {31'b0, if2.Ready}, 32'd0);
    chk("w2_busy_clr",  {31'b0, if2.Busy},  32'd0);
  endtask

  task automatic acc0(input logic wr, input logic [31:0] adr, input logic [31:0] wd,
                      input logic [31:0] exp_rd);
    if0.Req = 1'b1; if0.MemWrite = wr; if0.Adr = adr; if0.WriteData = wd;
    @(negedge clk);
    chk("w0_ready", {31'b0, if0.Ready}, 32'd1);
    chk("w0_busy",  {31'b0, if0.Busy},  32'd1);
    chk("w0_rdata", if0.ReadData, exp_rd);
    if0.Req = 1'b0;
    @(negedge clk);
    chk("w0_ready_clr", {31'b0, if0.Ready}, 32'd0);
    chk("w0_busy_clr",  {31'b0, if0.Busy},  32'd0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1'b1;
    if2.Req = 1'b0; if2.MemWrite = 1'b0; if2.Adr = '0; if2.WriteData = '0;
    if0.Req = 1'b1; if0.MemWrite = 1'b1; if0.Adr = '0; if0.WriteData = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("rst_ready2", {31'b0, if2.Ready}, 32'd0);
    chk("rst_busy2",  {31'b0, if2.Busy},  32'd0);
    chk("rst_err2",   {31'b0, if2.Err},   32'd0);
    chk("rst_rdata2", if2.ReadData, 32'h0);
    chk("rst_ready0", {31'b0, if0.Ready}, 32'd0);
    chk("rst_busy0",  {31'b0, if0.Busy},  32'd0);
    chk("rst_rdata0", if0.ReadData, 32'h0);
    if0.Req = 1'b0;
    reset = 1'b0;

    // Zero wait states: fill words 0 and 1, then back-to-back reads with Req held.
    acc0(1'b1, 32'h0, 32'h0000_AAAA, 32'h0);
    acc0(1'b1, 32'h4, 32'h0000_BBBB, 32'h0);
    if0.Req = 1'b1; if0.MemWrite = 1'b0; if0.Adr = 32'h0;
    @(negedge clk);
    chk("b2b_ready1", {31'b0, if0.Ready}, 32'd1);
    chk("b2b_busy1",  {31'b0, if0.Busy},  32'd1);
    chk("b2b_rd0",    if0.ReadData, 32'h0000_AAAA);
    if0.Adr = 32'h4;
    @(negedge clk);
    chk("b2b_gap_ready", {31'b0, if0.Ready}, 32'd0);
    chk("b2b_gap_busy",  {31'b0, if0.Busy},  32'd0);
    @(negedge clk);
    chk("b2b_ready2", {31'b0, if0.Ready}, 32'd1);
    chk("b2b_rd4",    if0.ReadData, 32'h0000_BBBB);
    if0.Req = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {31'b0, if0.Busy}, 32'd0);

    // Two wait states: basic write/read, error accesses, aliasing write.
    acc2(1'b1, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0);
    acc2(1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0);
    acc2(1'b1, 32'h0,   32'h1111_0000, 32'hDEAD_BEEF, 1'b0);
    acc2(1'b0, 32'h102, 32'h0,         32'h0,         1'b1);
    acc2(1'b0, 32'h400, 32'h0,         32'h0,         1'b1);
    acc2(1'b1, 32'h400, 32'hFFFF_FFFF, 32'h0,         1'b1);
    acc2(1'b0, 32'h0,   32'h0,         32'h1111_0000, 1'b0);
    acc2(1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0);
    acc2(1'b1, 32'h8,   32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0);

    // Reset in the second wait cycle aborts a pending write.
    if2.Req = 1'b1; if2.MemWrite = 1'b1; if2.Adr = 32'h8; if2.WriteData = 32'h1234_5678;
    @(negedge clk);
    chk("abort_ready_w1", {31'b0, if2.Ready}, 32'd0);
    @(negedge clk);
    chk("abort_ready_w2", {31'b0, if2.Ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'b0, if2.Ready}, 32'd0);
    chk("abort_busy",  {31'b0, if2.Busy},  32'd0);
    chk("abort_rdata", if2.ReadData, 32'h0);
    reset = 1'b0; if2.Req = 1'b0;
    @(negedge clk);
    acc2(1'b0, 32'h8, 32'h0, 32'h0BAD_F00D, 1'b0);

    // Req toggled mid-access with a different address is ignored.
    if2.Req = 1'b1; if2.MemWrite = 1'b0; if2.Adr = 32'h10;
    @(negedge clk);
    if2.Req = 1'b0; if2.MemWrite = 1'b1; if2.Adr = 32'h8; if2.WriteData = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("tog_ready_w", {31'b0, if2.Ready}, 32'd0);
    if2.Req = 1'b1;
    @(negedge clk);
    chk("tog_ready", {31'b0, if2.Ready}, 32'd1);
    chk("tog_rdata", if2.ReadData, 32'hDEAD_BEEF);
    chk("tog_err",   {31'b0, if2.Err}, 32'd0);
    if2.Req = 1'b0;
    @(negedge clk);
    chk("tog_idle", {31'b0, if2.Busy}, 32'd0);
    acc2(1'b0, 32'h8, 32'h0, 32'h0BAD_F00D, 1'b0);

    // Last word of the array.
    acc2(1'b1, 32'hFC, 32'hA5A5_A5A5, 32'h0BAD_F00D, 1'b0);
    acc2(1'b0, 32'hFC, 32'h0,         32'hA5A5_A5A5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
